seq_divider: RTL

//  Multi-cycle radix-2 non-restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.

---
 rtl/seq_divider.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 non-restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// One division in flight; start/busy/done handshake, results held until the next done.
module seq_divider #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   mdiv_q, mdiv_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               povf_q, povf_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;
  logic               overflow_q, overflow_d;

  logic               dvd_neg, dvs_neg, q_neg, range_ovf, err;
  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_mag, rem_mag;
  logic [WIDTH:0]     prem_sh, prem_new;

  assign dvd_neg = SIGNED && dvd_q[2*WIDTH-1];
  assign dvs_neg = SIGNED && dvs_q[WIDTH-1];
  assign q_neg   = dvd_neg ^ dvs_neg;
  assign dvd_mag = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_mag = dvs_neg ? -dvs_q : dvs_q;

  // Partial remainder wraps mod 2^(WIDTH+1); every post-step value lies in [-M, M) so it stays exact.
  assign prem_sh  = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign prem_new = prem_q[WIDTH] ? (prem_sh + {1'b0, mdiv_q}) : (prem_sh - {1'b0, mdiv_q});
  assign rem_mag  = prem_q[WIDTH] ? (prem_q[WIDTH-1:0] + mdiv_q) : prem_q[WIDTH-1:0];

  assign range_ovf = SIGNED && (q_neg ? (quo_q > MIN_MAG) : (quo_q > MAX_POS));
  assign err       = dz_q || povf_q || range_ovf;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    mdiv_d      = mdiv_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    dz_d        = dz_q;
    povf_d      = povf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        dz_d    = (dvs_q == '0);
        povf_d  = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
        prem_d  = {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
        quo_d   = dvd_mag[WIDTH-1:0];
        mdiv_d  = dvs_mag;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_ITER;
      end
      S_ITER: begin
        prem_d = prem_new;
        quo_d  = {quo_q[WIDTH-2:0], ~prem_new[WIDTH]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = err ? '1 : (q_neg ? -quo_q : quo_q);
        remainder_d = err ? dvd_q[WIDTH-1:0] : (dvd_neg ? -rem_mag : rem_mag);
        div_zero_d  = dz_q;
        overflow_d  = !dz_q && (povf_q || range_ovf);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      mdiv_q      <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      povf_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      mdiv_q      <= mdiv_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      povf_q      <= povf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
